// File: rtl/apb_master_req_if.sv
// Command, APB and response signals of the APB requester, bundled with a
// master view (the requester) and a slave view (the bus/command environment).
interface apb_master_req_if #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [AWIDTH-1:0] cmd_addr;
    logic [DWIDTH-1:0] cmd_wdata;

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [AWIDTH-1:0] PADDR;
    logic [DWIDTH-1:0] PWDATA;
    logic [DWIDTH-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    logic              rsp_valid;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    // Debug view of the requester FSM: 0=IDLE, 1=SETUP, 2=ACCESS.
    logic [1:0]        fsm_state;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output fsm_state
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  fsm_state
    );
endinterface

// File: rtl/apb_master_req.sv
// APB requester: takes one command at a time, runs SETUP/ACCESS with wait
// states and timeout, and reports the outcome on a one-cycle response strobe.
module apb_master_req #(
    parameter int DWIDTH  = 8,
    parameter int AWIDTH  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic PCLK,
    input  logic PRESET,
    apb_master_req_if.master bus
);
    // Command handshake: a command transfers on a PCLK edge where
    // cmd_valid & cmd_ready; cmd_ready is high only in IDLE and never in reset.
    // The response strobe has no backpressure.

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW:0] TO_LIMIT = (CW+1)'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     wait_cnt, wait_cnt_nxt;
    logic [CW:0]       cnt_inc;
    logic              pwrite, pwrite_nxt;
    logic [AWIDTH-1:0] paddr, paddr_nxt;
    logic [DWIDTH-1:0] pwdata, pwdata_nxt;
    logic              rsp_valid, rsp_valid_nxt;
    logic [DWIDTH-1:0] rsp_rdata, rsp_rdata_nxt;
    logic              rsp_err, rsp_err_nxt;
    logic              rsp_timeout, rsp_timeout_nxt;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            pwrite      <= pwrite_nxt;
            paddr       <= paddr_nxt;
            pwdata      <= pwdata_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            rsp_err     <= rsp_err_nxt;
            rsp_timeout <= rsp_timeout_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        pwrite_nxt      = pwrite;
        paddr_nxt       = paddr;
        pwdata_nxt      = pwdata;
        rsp_valid_nxt   = 1'b0;
        rsp_rdata_nxt   = rsp_rdata;
        rsp_err_nxt     = rsp_err;
        rsp_timeout_nxt = rsp_timeout;
        // One extra bit so the count can reach TIMEOUT without wrapping.
        cnt_inc         = {1'b0, wait_cnt} + (CW+1)'(1);

        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_nxt    = SETUP;
                    wait_cnt_nxt = '0;
                    pwrite_nxt   = bus.cmd_write;
                    paddr_nxt    = bus.cmd_addr;
                    pwdata_nxt   = bus.cmd_wdata;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                // A slave that answers on the last allowed cycle still wins.
                if (bus.PREADY) begin
                    state_nxt       = IDLE;
                    rsp_valid_nxt   = 1'b1;
                    rsp_rdata_nxt   = pwrite ? '0 : bus.PRDATA;
                    rsp_err_nxt     = bus.PSLVERR;
                    rsp_timeout_nxt = 1'b0;
                end else if ((TIMEOUT != 0) && (cnt_inc == TO_LIMIT)) begin
                    state_nxt       = IDLE;
                    rsp_valid_nxt   = 1'b1;
                    rsp_rdata_nxt   = '0;
                    rsp_err_nxt     = 1'b1;
                    rsp_timeout_nxt = 1'b1;
                end else begin
                    wait_cnt_nxt = cnt_inc[CW-1:0];
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // PSEL/PENABLE decode straight from the state register, so an async
    // reset drops the bus immediately.
    assign bus.PSEL        = (state != IDLE);
    assign bus.PENABLE     = (state == ACCESS);
    assign bus.cmd_ready   = (state == IDLE) && !PRESET;
    assign bus.PWRITE      = pwrite;
    assign bus.PADDR       = paddr;
    assign bus.PWDATA      = pwdata;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_rdata   = rsp_rdata;
    assign bus.rsp_err     = rsp_err;
    assign bus.rsp_timeout = rsp_timeout;
    assign bus.fsm_state   = state;
endmodule

// File: doc/apb_master_req.md
Name: apb_master_req

Overview:
- APB requester (master) that drives the APB bus towards the team's register slaves, e.g. the 8-bit RW register blocks.
- Accepts one command at a time on a valid/ready command port and runs the APB SETUP/ACCESS sequence.
- Honours PREADY wait states and PSLVERR, and aborts hung transfers with a timeout.
- Returns read data and status on a single-cycle response strobe.

Parameters:
DWIDTH, 8, data width of PWDATA/PRDATA/cmd_wdata/rsp_rdata
AWIDTH, 8, address width of PADDR/cmd_addr
TIMEOUT, 16, max consecutive ACCESS cycles with PREADY=0 before abort; 0 disables timeout

Ports:
PCLK        input   1       clock, all logic on rising edge
PRESET      input   1       asynchronous, active-high reset
cmd_valid   input   1       command request
cmd_ready   output  1       command accepted when cmd_valid & cmd_ready at PCLK edge
cmd_write   input   1       1=write, 0=read
cmd_addr    input   AWIDTH  transfer address
cmd_wdata   input   DWIDTH  write data
PSEL        output  1       APB select
PENABLE     output  1       APB enable
PWRITE      output  1       APB direction
PADDR       output  AWIDTH  APB address
PWDATA      output  DWIDTH  APB write data
PRDATA      input   DWIDTH  APB read data from slave
PREADY      input   1       slave ready / wait-state control
PSLVERR     input   1       slave error
rsp_valid   output  1       one-cycle response strobe, no backpressure
rsp_rdata   output  DWIDTH  read data; 0 for writes and timeouts
rsp_err     output  1       PSLVERR at completion, or timeout
rsp_timeout output  1       transfer aborted by timeout

Behaviour:
- Reset (async, PRESET=1) forces:
  - FSM to IDLE; wait counter to 0.
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0.
  - cmd_ready combinational: equals (state==IDLE) and is 0 while PRESET=1.
- Reset mid-transfer: bus drops immediately, no response is produced, and the command is lost.
- FSM states and transitions:
  - IDLE: cmd_ready=1. On an edge with cmd_valid=1, latch cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA and go to SETUP.
  - SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then go to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable.
    - On an edge with PREADY=1: complete the transfer and go to IDLE.
    - PREADY=0: stay in ACCESS and increment the wait counter.
    - Wait counter reaching TIMEOUT (TIMEOUT>0): abort and go to IDLE.
- Completion (registered, visible the cycle after the completing edge):
  - PSEL=0, PENABLE=0, rsp_valid=1 for exactly one cycle.
  - Read: rsp_rdata=PRDATA sampled at the completing edge.
  - Write: rsp_rdata=0.
  - rsp_err=PSLVERR sampled at the completing edge; rsp_timeout=0.
  - PSLVERR and PRDATA are ignored at all other times.
- Timeout abort: rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0; PSEL/PENABLE drop in the same cycle.
- Wait counter: cleared on entry to SETUP; width is clog2(TIMEOUT+1) with a minimum of 1; must not wrap before comparison.
- Latency:
  - Command accept edge to PSEL rising: 1 cycle.
  - Zero-wait transfer: SETUP 1 cycle + ACCESS 1 cycle; rsp_valid in the following cycle.
  - N wait states add N cycles.
- Back-to-back commands: cmd_ready is high in the same cycle rsp_valid is high. A command accepted there enters SETUP on the next edge, giving at least 1 idle bus cycle between transfers.
- Holding values:
  - PADDR/PWRITE/PWDATA keep their last values while idle.
  - rsp_rdata/rsp_err/rsp_timeout hold until the next response.
- cmd_* inputs are ignored outside IDLE.

Test Plan:
- Write 0xA5 to addr 0x10, PREADY=1:
  - PSEL rises 1 cycle after accept; PENABLE 1 cycle later with PWRITE=1, PADDR=0x10, PWDATA=0xA5.
  - rsp_valid pulse with rsp_err=0, rsp_rdata=0.
- Read addr 0x10, slave returns PRDATA=0x3C, 3 wait states: ACCESS lasts 4 cycles, addr stable throughout; rsp_rdata=0x3C, rsp_err=0.
- Read with PSLVERR=1 at completion: rsp_err=1, rsp_timeout=0; PSLVERR=1 during wait cycles alone has no effect.
- PREADY held 0, TIMEOUT=16: abort after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0; PSEL=0 afterwards.
- cmd_valid held high for 3 writes (0x01, 0x02, 0x03): three transfers in order; cmd_ready high only in IDLE; a 1-cycle PSEL=0 gap between transfers.
- PRESET pulse during ACCESS: PSEL/PENABLE go 0 asynchronously, no rsp_valid; the next command after release completes normally.
